pin_io_frontend: RTL and testbench

PIN_IO_FRONTEND -- requirements
Module: pin_io_frontend

---
 rtl/pin_io_frontend.sv | 137 +++++++++++++
 tb/tb_pin_io_frontend.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_io_frontend.sv
// Pin-level front end: config capture, RAM pin mux, rx sync, video/uio output regs, frame-event counter.
// Optional sticky event-drop flag is built only when PIN_IO_EV_OVERFLOW_EN is defined.
module pin_io_frontend #(
  parameter int RAM_PINS = 4,
  parameter int IO_BITS  = 2,
  parameter int RX_SYNC  = 1,
  parameter int EV_DEPTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_sample,
  input  logic [7:0]          ui_in,
  input  logic [7:0]          uio_in,
  output logic [7:0]          uo_out,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe,
  output logic [3:0]          cfg_out,
  input  logic [11:0]         rgb_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                active_in,
  input  logic                pix_phase_in,
  input  logic                ppu_reset,
  input  logic                sync_data,
  input  logic [RAM_PINS-1:0] addr_in,
  output logic [RAM_PINS-1:0] data_out,
  input  logic [IO_BITS-1:0]  tx_in,
  output logic [IO_BITS-1:0]  rx_out,
  input  logic                event_en,
  input  logic                new_frame,
  output logic                ev_request,
  input  logic                ev_ack,
  output logic                ev_overflow
);

  localparam int RX_HI = RAM_PINS + IO_BITS - 1;

  logic                rx_alt;
  logic [7:0]          ui_q;
  logic [7:0]          uio_q;
  logic [IO_BITS-1:0]  rx_src;
  logic [IO_BITS-1:0]  rx_pipe [RX_SYNC];
  logic [7:0]          uio_nxt;
  logic [3:0]          cnt;
  logic [3:0]          cnt_nxt;
  logic                inc;
  logic                dec;
  logic                at_max;

  assign rx_alt = cfg_out[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_out <= '0;
      ui_q    <= '0;
      uio_q   <= '0;
    end else begin
      if (cfg_sample) cfg_out <= ui_in[3:0];
      ui_q  <= ui_in;
      uio_q <= uio_in;
    end
  end

  assign data_out = sync_data ? ui_q[RAM_PINS-1:0] : ui_in[RAM_PINS-1:0];

  // rx comes from spare dedicated inputs in alt mode, else from the top uio bits
  assign rx_src = rx_alt ? ui_in[RX_HI:RAM_PINS] : uio_in[7:8-IO_BITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RX_SYNC; i++) rx_pipe[i] <= '0;
    end else begin
      rx_pipe[0] <= rx_src;
      for (int i = 1; i < RX_SYNC; i++) rx_pipe[i] <= rx_pipe[i-1];
    end
  end

  assign rx_out = rx_pipe[RX_SYNC-1];

  always_comb begin
    uio_nxt                 = '0;
    uio_nxt[RAM_PINS-1:0]   = ppu_reset ? data_out : addr_in;
    uio_nxt[RX_HI:RAM_PINS] = tx_in;
    uio_nxt[6]              = active_in;
    uio_nxt[7]              = pix_phase_in & rx_alt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uo_out  <= '0;
      uio_out <= '0;
    end else begin
      // two MSBs of each colour channel plus syncs
      uo_out  <= {hsync_in, rgb_in[2], rgb_in[6], rgb_in[10],
                  vsync_in, rgb_in[3], rgb_in[7], rgb_in[11]};
      uio_out <= uio_nxt;
    end
  end

  assign uio_oe = {{2{rx_alt}}, 6'h3F};

  assign inc    = new_frame & ~ppu_reset;
  assign dec    = ev_ack & (cnt != 4'd0);
  assign at_max = (cnt == 4'(EV_DEPTH));

  always_comb begin
    cnt_nxt = cnt;
    if (!event_en)                   cnt_nxt = '0;
    else if (inc && !dec && !at_max) cnt_nxt = cnt + 4'd1;
    else if (dec && !inc)            cnt_nxt = cnt - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      ev_request <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      ev_request <= (cnt_nxt != 4'd0);
    end
  end

`ifdef PIN_IO_EV_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         ovf_q <= 1'b0;
    else if (!event_en)                ovf_q <= 1'b0;
    else if (inc && !dec && at_max)    ovf_q <= 1'b1;
  end

  assign ev_overflow = ovf_q;
`else
  assign ev_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pin_io_frontend.sv
// Scoreboard bench for pin_io_frontend: driver pushes model expectations, monitor compares mid-cycle.
module tb_pin_io_frontend;
  localparam int RP  = 4;
  localparam int IB  = 2;
  localparam int RXS = 2;
  localparam int DEP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cfg_sample, hsync_in, vsync_in, active_in, pix_phase_in;
  logic          ppu_reset, sync_data, event_en, new_frame, ev_ack;
  logic [7:0]    ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic [3:0]    cfg_out;
  logic [11:0]   rgb_in;
  logic [RP-1:0] addr_in, data_out;
  logic [IB-1:0] tx_in, rx_out;
  logic          ev_request, ev_overflow;

  pin_io_frontend #(.RAM_PINS(RP), .IO_BITS(IB), .RX_SYNC(RXS), .EV_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .cfg_sample(cfg_sample), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .cfg_out(cfg_out), .rgb_in(rgb_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in), .pix_phase_in(pix_phase_in),
    .ppu_reset(ppu_reset), .sync_data(sync_data), .addr_in(addr_in), .data_out(data_out),
    .tx_in(tx_in), .rx_out(rx_out), .event_en(event_en), .new_frame(new_frame),
    .ev_request(ev_request), .ev_ack(ev_ack), .ev_overflow(ev_overflow)
  );

  typedef struct {
    logic rst, smp;
    logic [7:0] ui, uio;
    logic [11:0] rgb;
    logic hs, vs, act, pix, ppr, sync;
    logic [RP-1:0] addr;
    logic [IB-1:0] tx;
    logic en, nf, ack;
  } stim_t;

  typedef struct {
    logic [3:0] cfg;
    logic [7:0] uo, uio, oe;
    logic [RP-1:0] dout;
    logic [IB-1:0] rx;
    logic req, ovf;
  } exp_t;

  // reference model state
  logic [3:0]    m_cfg;
  logic [7:0]    m_ui_q, m_uo, m_uio;
  int            m_cnt;
  logic          m_ovf;
  logic [IB-1:0] m_rx_hist[$];

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  stim_t cur;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.en = 1'b1;
    return s;
  endfunction

  function automatic void m_reset();
    m_cfg = '0; m_ui_q = '0; m_uo = '0; m_uio = '0; m_cnt = 0; m_ovf = 1'b0;
    m_rx_hist.delete();
    repeat (RXS) m_rx_hist.push_back('0);
  endfunction

  function automatic void m_step(stim_t s);
    logic [3:0] r, g, b;
    logic [RP-1:0] dout;
    int inc, dec;
    if (s.rst) begin
      m_reset();
      return;
    end
    {r, g, b} = s.rgb;
    m_uo = {s.hs, b[2], g[2], r[2], s.vs, b[3], g[3], r[3]};
    dout = s.sync ? m_ui_q[RP-1:0] : s.ui[RP-1:0];
    m_uio = '0;
    m_uio[RP-1:0] = s.ppr ? dout : s.addr;
    m_uio[RP+IB-1 -: IB] = s.tx;
    m_uio[6] = s.act;
    m_uio[7] = s.pix & m_cfg[0];
    m_rx_hist.push_back(m_cfg[0] ? s.ui[RP+IB-1 -: IB] : s.uio[7 -: IB]);
    void'(m_rx_hist.pop_front());
    if (!s.en) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      inc = (s.nf && !s.ppr) ? 1 : 0;
      dec = (s.ack && m_cnt > 0) ? 1 : 0;
      m_cnt = m_cnt + inc - dec;
      if (m_cnt > DEP) begin
        m_cnt = DEP;
`ifdef PIN_IO_EV_OVERFLOW_EN
        m_ovf = 1'b1;
`endif
      end
    end
    if (s.smp) m_cfg = s.ui[3:0];
    m_ui_q = s.ui;
  endfunction

  function automatic exp_t m_expect(stim_t s);
    exp_t e;
    e.cfg  = m_cfg;
    e.uo   = m_uo;
    e.uio  = m_uio;
    e.oe   = m_cfg[0] ? 8'hFF : 8'h3F;
    e.dout = s.sync ? m_ui_q[RP-1:0] : s.ui[RP-1:0];
    e.rx   = m_rx_hist[0];
    e.req  = (m_cnt != 0);
    e.ovf  = m_ovf;
    return e;
  endfunction

  task automatic apply(stim_t s);
    reset = s.rst; cfg_sample = s.smp; ui_in = s.ui; uio_in = s.uio; rgb_in = s.rgb;
    hsync_in = s.hs; vsync_in = s.vs; active_in = s.act; pix_phase_in = s.pix;
    ppu_reset = s.ppr; sync_data = s.sync; addr_in = s.addr; tx_in = s.tx;
    event_en = s.en; new_frame = s.nf; ev_ack = s.ack;
  endtask

  // one clock: model absorbs the edge, then the next stimulus goes out with its expectation
  task automatic cycle(stim_t s);
    @(posedge clk);
    m_step(cur);
    #1;
    cur = s;
    apply(s);
    if (s.rst) m_reset();
    sb.push_back(m_expect(s));
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cfg_out",     32'(cfg_out),     32'(e.cfg));
        chk("uo_out",      32'(uo_out),      32'(e.uo));
        chk("uio_out",     32'(uio_out),     32'(e.uio));
        chk("uio_oe",      32'(uio_oe),      32'(e.oe));
        chk("data_out",    32'(data_out),    32'(e.dout));
        chk("rx_out",      32'(rx_out),      32'(e.rx));
        chk("ev_request",  32'(ev_request),  32'(e.req));
        chk("ev_overflow", 32'(ev_overflow), 32'(e.ovf));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    stim_t s;
    cur = idle();
    cur.rst = 1'b1;
    apply(cur);
    m_reset();

    s = idle(); s.rst = 1'b1;
    repeat (3) cycle(s);

    // cfg sampled on the very first cycle out of reset, then held
    s = idle(); s.smp = 1'b1; s.ui = 8'h0B; cycle(s);
    s = idle(); cycle(s); cycle(s);
    s.smp = 1'b1; s.ui = 8'h02; cycle(s);
    s = idle(); cycle(s);

    // RAM pin loopback, async then registered
    s = idle(); s.ppr = 1'b1; s.ui = 8'h05; cycle(s); cycle(s);
    s.ppr = 1'b0; s.addr = 4'hA; cycle(s); cycle(s);
    s = idle(); s.sync = 1'b1; s.ui = 8'h09; cycle(s); s.ui = 8'h03; cycle(s);

    // event counting, simultaneous inc/dec, saturation, disable
    s = idle();
    repeat (3) begin s.nf = 1'b1; cycle(s); s.nf = 1'b0; cycle(s); end
    s.ack = 1'b1; cycle(s); s.ack = 1'b0; cycle(s);
    s.nf = 1'b1; s.ack = 1'b1; cycle(s);
    s = idle(); cycle(s);
    s.nf = 1'b1; repeat (5) cycle(s);
    s = idle(); cycle(s);
    s.en = 1'b0; cycle(s);
    s = idle(); s.ack = 1'b1; repeat (3) cycle(s);
    s = idle(); s.nf = 1'b1; s.ppr = 1'b1; cycle(s);

    // rx latency through the synchroniser
    s = idle(); cycle(s);
    s.uio = 8'h80; repeat (4) cycle(s);
    s.uio = 8'h40; repeat (3) cycle(s);

    // async reset mid-stream
    s = idle(); s.nf = 1'b1; s.rgb = 12'hFFF; s.tx = 2'b11; s.act = 1'b1; s.hs = 1'b1;
    cycle(s); cycle(s);
    s = idle(); s.rst = 1'b1; s.ui = 8'hFF; s.sync = 1'b1; cycle(s);
    s = idle(); cycle(s);

    repeat (600) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.smp  = ($urandom_range(0, 7) == 0);
      s.ui   = 8'($urandom);
      s.uio  = 8'($urandom);
      s.rgb  = 12'($urandom);
      s.hs   = 1'($urandom); s.vs = 1'($urandom);
      s.act  = 1'($urandom); s.pix = 1'($urandom);
      s.ppr  = ($urandom_range(0, 3) == 0);
      s.sync = 1'($urandom);
      s.addr = RP'($urandom);
      s.tx   = IB'($urandom);
      s.en   = ($urandom_range(0, 19) != 0);
      s.nf   = ($urandom_range(0, 1) == 0);
      s.ack  = ($urandom_range(0, 9) < 4);
      cycle(s);
    end

    s = idle();
    cycle(s);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
